cuckoo_req_driver: RTL and testbench



---
 rtl/cuckoo_pkg.sv | 9 +
 rtl/cuckoo_req_driver_if.sv | 28 ++
 rtl/cuckoo_mask_scan.sv | 17 +
 rtl/cuckoo_req_driver.sv | 83 ++++++++
 tb/tb_cuckoo_req_driver.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cuckoo_pkg.sv
// cuckoo_pkg: width constants, empty-key sentinel and driver states shared with the table
package cuckoo_pkg;
  localparam int KEY_WIDTH = 33;
  localparam int VALUE_WIDTH = 32;
  localparam int NUM_OFFSETS = 8;
  localparam int OFF_WIDTH = $clog2(NUM_OFFSETS);
  localparam logic [KEY_WIDTH-1:0] EMPTY_KEY = '0;
  typedef enum logic [2:0] {IDLE, WRITE, PROBE, RESTORE, DRAIN, RESP} state_t;
endpackage

// File: rtl/cuckoo_req_driver_if.sv
// cuckoo_req_driver_if: command, response and table-port signals of the request driver
interface cuckoo_req_driver_if;
  import cuckoo_pkg::*;
  logic cmd_valid;
  logic cmd_ready;
  logic cmd_write;
  logic [KEY_WIDTH-1:0] cmd_key;
  logic [NUM_OFFSETS-1:0] cmd_mask;
  logic [NUM_OFFSETS*VALUE_WIDTH-1:0] cmd_data;
  logic rsp_valid;
  logic rsp_ready;
  logic [NUM_OFFSETS*VALUE_WIDTH-1:0] rsp_data;
  logic rsp_collision;
  logic rsp_err;
  logic [KEY_WIDTH-1:0] tbl_key;
  logic [OFF_WIDTH-1:0] tbl_offset;
  logic [VALUE_WIDTH-1:0] tbl_value;
  logic [VALUE_WIDTH-1:0] tbl_lookup_result;
  logic tbl_collision;
  modport master (
    input cmd_valid, cmd_write, cmd_key, cmd_mask, cmd_data, rsp_ready, tbl_lookup_result, tbl_collision,
    output cmd_ready, rsp_valid, rsp_data, rsp_collision, rsp_err, tbl_key, tbl_offset, tbl_value
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_key, cmd_mask, cmd_data, rsp_ready, tbl_lookup_result, tbl_collision,
    input cmd_ready, rsp_valid, rsp_data, rsp_collision, rsp_err, tbl_key, tbl_offset, tbl_value
  );
endinterface

// File: rtl/cuckoo_mask_scan.sv
// cuckoo_mask_scan: lowest set mask bit strictly above cur; done when none remains
module cuckoo_mask_scan import cuckoo_pkg::*; (
  input  logic [NUM_OFFSETS-1:0] mask,
  input  logic [OFF_WIDTH-1:0]   cur,
  output logic [OFF_WIDTH-1:0]   nxt,
  output logic                   done
);
  always_comb begin
    nxt = cur;
    done = 1'b1;
    for (int i = NUM_OFFSETS - 1; i >= 0; i--)
      if (i > int'(cur) && mask[i]) begin
        nxt = OFF_WIDTH'(i);
        done = 1'b0;
      end
  end
endmodule

// File: rtl/cuckoo_req_driver.sv
// cuckoo_req_driver: serializes whole-record commands into per-offset table beats, one 256-bit response each
module cuckoo_req_driver import cuckoo_pkg::*; (
  input logic clk,
  input logic rst,
  cuckoo_req_driver_if.master bus
);
  state_t state, state_nxt;
  logic [KEY_WIDTH-1:0] key;
  logic [NUM_OFFSETS-1:0] mask, scan_mask;
  logic [NUM_OFFSETS*VALUE_WIDTH-1:0] data, rsp_buf;
  logic [OFF_WIDTH-1:0] off, scan_cur, scan_nxt;
  logic col_base, scan_done, idle, beat, accept, no_beats, rsp_col, err;
  always_comb begin
    idle = state == IDLE;
    beat = state == WRITE || state == PROBE || state == RESTORE;
    accept = idle && bus.cmd_valid;
    no_beats = bus.cmd_key == EMPTY_KEY || (bus.cmd_write && bus.cmd_mask == '0);
    scan_mask = idle ? bus.cmd_mask : mask;
    scan_cur = idle ? '0 : off;
  end
  cuckoo_mask_scan u_scan (
    .mask(scan_mask),
    .cur (scan_cur),
    .nxt (scan_nxt),
    .done(scan_done)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.cmd_valid) state_nxt = no_beats ? RESP : bus.cmd_write ? WRITE : PROBE;
      WRITE:   if (scan_done) state_nxt = DRAIN;
      PROBE:   state_nxt = RESTORE;
      RESTORE: state_nxt = off == OFF_WIDTH'(NUM_OFFSETS - 1) ? DRAIN : PROBE;
      DRAIN:   state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // the restore beat writes back the value the probe just displaced, captured into the response at the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key <= '0;
      mask <= '0;
      data <= '0;
      off <= '0;
      col_base <= 1'b0;
      rsp_buf <= '0;
      rsp_col <= 1'b0;
      err <= 1'b0;
    end else if (accept) begin
      key <= bus.cmd_key;
      mask <= bus.cmd_mask;
      data <= bus.cmd_data;
      col_base <= bus.tbl_collision;
      off <= (!bus.cmd_write || bus.cmd_mask[0]) ? '0 : scan_nxt;
      rsp_buf <= '0;
      rsp_col <= 1'b0;
      err <= bus.cmd_key == EMPTY_KEY;
    end else if (state == WRITE) begin
      off <= scan_nxt;
    end else if (state == RESTORE) begin
      rsp_buf[off*VALUE_WIDTH +: VALUE_WIDTH] <= bus.tbl_lookup_result;
      off <= off + 1'b1;
    end else if (state == DRAIN) begin
      rsp_col <= bus.tbl_collision && !col_base;
    end
  end
  always_comb begin
    bus.cmd_ready = idle;
    bus.rsp_valid = state == RESP;
    bus.rsp_data = rsp_buf;
    bus.rsp_collision = rsp_col;
    bus.rsp_err = err;
    bus.tbl_key = beat ? key : EMPTY_KEY;
    bus.tbl_offset = beat ? off : '0;
    bus.tbl_value = state == WRITE ? data[off*VALUE_WIDTH +: VALUE_WIDTH] :
                    state == RESTORE ? bus.tbl_lookup_result : '0;
  end
endmodule

// File: tb/tb_cuckoo_req_driver.sv
// tb_cuckoo_req_driver: directed scenarios against a small cuckoo table model
module tb_cuckoo_req_driver;
  import cuckoo_pkg::*;
  typedef struct packed {
    logic [31:0] cyc;
    logic [KEY_WIDTH-1:0] key;
    logic [OFF_WIDTH-1:0] off;
    logic [VALUE_WIDTH-1:0] val;
  } beat_t;
  localparam logic [KEY_WIDTH-1:0] K = 33'h1_0000_0005;
  localparam logic [KEY_WIDTH-1:0] K2 = 33'h1_0000_0006;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  cuckoo_req_driver_if bus ();
  cuckoo_req_driver dut (.clk(clk), .rst(rst), .bus(bus));
  logic [255:0] mem [16] = '{default: '0};
  beat_t beats[$];
  logic [31:0] cyc = 0;
  logic [31:0] t0;
  int tests = 0;
  int fails = 0;
  // table model: registered lookup of the old word and insert on every edge; key 0 is the idle beat
  always @(posedge clk) begin
    if (bus.tbl_key != 0 || bus.tbl_offset != 0 || bus.tbl_value != 0)
      beats.push_back({cyc, bus.tbl_key, bus.tbl_offset, bus.tbl_value});
    if (bus.tbl_key != 0) begin
      bus.tbl_lookup_result <= mem[bus.tbl_key[3:0]][bus.tbl_offset*32 +: 32];
      mem[bus.tbl_key[3:0]][bus.tbl_offset*32 +: 32] <= bus.tbl_value;
    end else bus.tbl_lookup_result <= '0;
    cyc <= cyc + 1;
  end
  function automatic logic [255:0] words(input logic [31:0] base);
    logic [255:0] w;
    for (int k = 0; k < 8; k++) w[k*32 +: 32] = base + 32'(k);
    return w;
  endfunction
  task automatic send(input logic wr, input logic [KEY_WIDTH-1:0] k, input logic [7:0] m, input logic [255:0] d);
    @(negedge clk);
    bus.cmd_valid = 1;
    bus.cmd_write = wr;
    bus.cmd_key = k;
    bus.cmd_mask = m;
    bus.cmd_data = d;
    beats.delete();
    tests++;
    if (bus.cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL cmd_ready_at_accept got %b want 1", bus.cmd_ready);
    end
    @(posedge clk);
    t0 = cyc;
    #1 bus.cmd_valid = 0;
  endtask
  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.rsp_valid !== 1'b1 && lat < 40);
  endtask
  task automatic ack;
    bus.rsp_ready = 1;
    @(posedge clk);
    #1 bus.rsp_ready = 0;
  endtask
  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_collision, bus.rsp_err} !== 4'b1000) begin
      fails++;
      $display("FAIL reset_flags got %b want 1000", {bus.cmd_ready, bus.rsp_valid, bus.rsp_collision, bus.rsp_err});
    end
    tests++;
    if (bus.rsp_data !== '0) begin
      fails++;
      $display("FAIL reset_rsp_data got %h want 0", bus.rsp_data);
    end
    tests++;
    if ({bus.tbl_key, bus.tbl_offset, bus.tbl_value} !== '0) begin
      fails++;
      $display("FAIL reset_tbl got %h/%h/%h want 0", bus.tbl_key, bus.tbl_offset, bus.tbl_value);
    end
    @(negedge clk);
    rst = 0;
  endtask
  task automatic test_write_full;
    int lat;
    beat_t a, e;
    send(1, K, 8'hFF, words(32'h100));
    wait_rsp(lat);
    tests++;
    if (lat !== 10) begin fails++; $display("FAIL wfull_latency got %0d want 10", lat); end
    tests++;
    if ({bus.rsp_collision, bus.rsp_err} !== 2'b00 || bus.rsp_data !== '0) begin
      fails++;
      $display("FAIL wfull_rsp got col=%b err=%b data=%h want 0/0/0", bus.rsp_collision, bus.rsp_err, bus.rsp_data);
    end
    tests++;
    if (beats.size() !== 8) begin fails++; $display("FAIL wfull_beat_count got %0d want 8", beats.size()); end
    for (int k = 0; k < 8 && k < beats.size(); k++) begin
      a = beats[k];
      a.cyc = a.cyc - t0;
      e = {32'(k + 1), K, 3'(k), 32'h100 + 32'(k)};
      tests++;
      if (a !== e) begin fails++; $display("FAIL wfull_beat%0d got %h want %h", k, a, e); end
    end
    ack;
  endtask
  task automatic test_read(input logic [255:0] exp, input string name);
    int lat;
    beat_t a, e;
    send(0, K, 8'h00, '0);
    wait_rsp(lat);
    tests++;
    if (lat !== 18) begin fails++; $display("FAIL %s_latency got %0d want 18", name, lat); end
    tests++;
    if (bus.rsp_data !== exp) begin fails++; $display("FAIL %s_data got %h want %h", name, bus.rsp_data, exp); end
    tests++;
    if (beats.size() !== 16) begin fails++; $display("FAIL %s_beat_count got %0d want 16", name, beats.size()); end
    for (int j = 0; j < 16 && j < beats.size(); j++) begin
      a = beats[j];
      a.cyc = a.cyc - t0;
      e = {32'(j + 1), K, 3'(j / 2), (j % 2 == 1) ? exp[(j/2)*32 +: 32] : 32'h0};
      tests++;
      if (a !== e) begin fails++; $display("FAIL %s_beat%0d got %h want %h", name, j, a, e); end
    end
    ack;
  endtask
  task automatic test_write_mask;
    int lat;
    beat_t a;
    send(1, K, 8'h82, words(32'h200));
    wait_rsp(lat);
    tests++;
    if (lat !== 4) begin fails++; $display("FAIL wmask_latency got %0d want 4", lat); end
    tests++;
    if (beats.size() !== 2) begin fails++; $display("FAIL wmask_beat_count got %0d want 2", beats.size()); end
    if (beats.size() == 2) begin
      a = beats[0];
      a.cyc = a.cyc - t0;
      tests++;
      if (a !== {32'd1, K, 3'd1, 32'h201}) begin fails++; $display("FAIL wmask_beat0 got %h", a); end
      a = beats[1];
      a.cyc = a.cyc - t0;
      tests++;
      if (a !== {32'd2, K, 3'd7, 32'h207}) begin fails++; $display("FAIL wmask_beat1 got %h", a); end
    end
    ack;
  endtask
  task automatic test_no_beats(input logic wr, input logic [KEY_WIDTH-1:0] k, input logic [7:0] m, input logic exp_err, input string name);
    int lat;
    send(wr, k, m, words(32'h300));
    wait_rsp(lat);
    tests++;
    if (lat !== 1) begin fails++; $display("FAIL %s_latency got %0d want 1", name, lat); end
    tests++;
    if ({bus.rsp_err, bus.rsp_collision} !== {exp_err, 1'b0}) begin
      fails++;
      $display("FAIL %s_flags got err=%b col=%b want err=%b col=0", name, bus.rsp_err, bus.rsp_collision, exp_err);
    end
    tests++;
    if (beats.size() !== 0) begin fails++; $display("FAIL %s_beats got %0d want 0", name, beats.size()); end
    ack;
  endtask
  task automatic test_collision;
    int lat;
    send(1, K2, 8'h03, words(32'h400));
    bus.tbl_collision = 1;
    wait_rsp(lat);
    tests++;
    if (lat !== 4 || bus.rsp_collision !== 1'b1) begin
      fails++;
      $display("FAIL col_new got lat=%0d col=%b want 4/1", lat, bus.rsp_collision);
    end
    ack;
    send(1, K2, 8'h01, words(32'h500));
    wait_rsp(lat);
    tests++;
    if (lat !== 3 || bus.rsp_collision !== 1'b0) begin
      fails++;
      $display("FAIL col_old got lat=%0d col=%b want 3/0", lat, bus.rsp_collision);
    end
    ack;
    bus.tbl_collision = 0;
  endtask
  task automatic test_backpressure;
    int lat;
    logic [255:0] exp;
    exp = '0;
    exp[31:0] = 32'h500;
    exp[63:32] = 32'h401;
    send(0, K2, 8'h00, '0);
    wait_rsp(lat);
    tests++;
    if (lat !== 18) begin fails++; $display("FAIL bp_latency got %0d want 18", lat); end
    bus.cmd_valid = 1;
    bus.cmd_write = 1;
    bus.cmd_key = K;
    bus.cmd_mask = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if ({bus.rsp_valid, bus.cmd_ready} !== 2'b10 || bus.rsp_data !== exp) begin
        fails++;
        $display("FAIL bp_hold%0d got valid=%b ready=%b data=%h want 1/0/%h", i, bus.rsp_valid, bus.cmd_ready, bus.rsp_data, exp);
      end
    end
    bus.cmd_valid = 0;
    tests++;
    if (beats.size() !== 16) begin fails++; $display("FAIL bp_beats got %0d want 16", beats.size()); end
    ack;
    tests++;
    if ({bus.cmd_ready, bus.rsp_valid} !== 2'b10) begin
      fails++;
      $display("FAIL bp_release got ready=%b valid=%b want 1/0", bus.cmd_ready, bus.rsp_valid);
    end
  endtask
  task automatic test_reset_mid;
    send(0, K, 8'h00, '0);
    repeat (5) @(negedge clk);
    tests++;
    if ({bus.tbl_key, bus.tbl_offset, bus.tbl_value} !== {K, 3'd2, 32'h0}) begin
      fails++;
      $display("FAIL mid_probe got %h/%h/%h want %h/2/0", bus.tbl_key, bus.tbl_offset, bus.tbl_value, K);
    end
    rst = 1;
    #1;
    tests++;
    if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_collision, bus.rsp_err} !== 4'b1000 || bus.rsp_data !== '0) begin
      fails++;
      $display("FAIL mid_rst_rsp got %b data=%h want 1000/0", {bus.cmd_ready, bus.rsp_valid, bus.rsp_collision, bus.rsp_err}, bus.rsp_data);
    end
    tests++;
    if ({bus.tbl_key, bus.tbl_offset, bus.tbl_value} !== '0) begin
      fails++;
      $display("FAIL mid_rst_tbl got %h/%h/%h want 0", bus.tbl_key, bus.tbl_offset, bus.tbl_value);
    end
    @(negedge clk);
    rst = 0;
  endtask
  initial begin
    logic [255:0] merged;
    bus.cmd_valid = 0;
    bus.cmd_write = 0;
    bus.cmd_key = '0;
    bus.cmd_mask = '0;
    bus.cmd_data = '0;
    bus.rsp_ready = 0;
    bus.tbl_collision = 0;
    test_reset;
    test_write_full;
    test_read(words(32'h100), "read1");
    test_read(words(32'h100), "read2");
    test_write_mask;
    merged = words(32'h100);
    merged[63:32] = 32'h201;
    merged[255:224] = 32'h207;
    test_read(merged, "read3");
    test_no_beats(1, '0, 8'hFF, 1, "key0_wr");
    test_no_beats(0, '0, 8'h00, 1, "key0_rd");
    test_no_beats(1, K, 8'h00, 0, "mask0");
    test_collision;
    test_backpressure;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
